// File: rtl/cpu_mc_pkg.sv
// Shared opcode map and FSM state encoding for the multicycle core.
package cpu_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SRL  = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BR   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_LI   = 4'hC;
  localparam logic [3:0] OP_LUI  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational ALU for the eight register-register opcodes.
// Shifts take the full B operand; any amount of DW or more yields zero.
module cpu_mc_alu
  import cpu_mc_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y,
  output logic          zero
);

  logic ovr;

  always_comb begin
    ovr = (b > DW'(DW - 1));
    y   = '0;
    case (op)
      OP_ADD[2:0]: y = a + b;
      OP_SUB[2:0]: y = a - b;
      OP_SRL[2:0]: y = ovr ? '0 : (a >> b);
      OP_SLL[2:0]: y = ovr ? '0 : (a << b);
      OP_OR[2:0]:  y = a | b;
      OP_AND[2:0]: y = a & b;
      OP_NOT[2:0]: y = ~a;
      OP_XOR[2:0]: y = a ^ b;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/cpu_mc.sv
// Multicycle load/store core: one instruction in flight, FETCH-DECODE-EXEC-[MEM]-WB.
// Instruction and data ports hold their request until the memory returns ready.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int NREG = 16
) (
  input  logic          CK,
  input  logic          RST,
  output logic [AW-1:0] IA,
  output logic          IREQ,
  input  logic          IRDY,
  input  logic [15:0]   ID,
  output logic [AW-1:0] DA,
  output logic          DREQ,
  output logic          DWE,
  output logic [DW-1:0] DWD,
  input  logic [DW-1:0] DRD,
  input  logic          DRDY,
  output logic          RETIRE,
  output logic          HALTED
);

  state_t        state, state_nxt;
  logic [AW-1:0] pc, npc, link;
  logic [15:0]   inst;
  logic [DW-1:0] rf [NREG];
  logic          flag;
  logic [DW-1:0] opa, opb, wb_val, wb_sel, lui_val, alu_y;
  logic          alu_zero;
  logic [3:0]    op, rc, ra, rb;
  logic [7:0]    imm;
  logic          is_alu, is_mem, rf_we, take;

  assign op  = inst[15:12];
  assign rc  = inst[11:8];
  assign ra  = inst[7:4];
  assign rb  = inst[3:0];
  assign imm = inst[7:0];

  cpu_mc_alu #(.DW(DW)) u_alu (
    .op   (op[2:0]),
    .a    (opa),
    .b    (opb),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    is_alu  = ~op[3];
    is_mem  = (op == OP_ST) || (op == OP_LD);
    rf_we   = is_alu || (op == OP_JMP) || (op == OP_LD) || (op == OP_LI) || (op == OP_LUI);
    take    = (op == OP_JMP) || ((op == OP_BR) && flag);
    lui_val = rf[rc];
    lui_val[15:8] = imm;
    wb_sel  = '0;
    case (op)
      OP_JMP:                      wb_sel = DW'(link);
      OP_LI:                       wb_sel = DW'(imm);
      OP_LUI:                      wb_sel = lui_val;
      OP_BR, OP_ST, OP_LD,
      OP_NOP, OP_HALT:             wb_sel = '0;
      default:                     wb_sel = alu_y;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) state <= FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (IRDY) state_nxt = DECODE;
      DECODE:  state_nxt = EXEC;
      EXEC:    state_nxt = is_mem ? MEM : WB;
      MEM:     if (DRDY) state_nxt = WB;
      WB:      state_nxt = (op == OP_HALT) ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    IA     = pc;
    IREQ   = (state == FETCH) && !RST;
    RETIRE = (state == WB) && !RST;
    HALTED = (state == HALT);
  end

  // Datapath: operands are latched in DECODE and held until WB so the ALU
  // output (and its zero flag) is still valid at write-back.
  always_ff @(posedge CK) begin
    if (RST) begin
      pc     <= '0;
      npc    <= '0;
      link   <= '0;
      inst   <= '0;
      flag   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      wb_val <= '0;
      DREQ   <= 1'b0;
      DWE    <= 1'b0;
      DWD    <= '0;
      DA     <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        FETCH: if (IRDY) inst <= ID;
        DECODE: begin
          opa  <= rf[ra];
          opb  <= rf[rb];
          link <= pc + AW'(1);
          npc  <= take ? rf[rb][AW-1:0] : pc + AW'(1);
        end
        EXEC: begin
          wb_val <= wb_sel;
          if (is_mem) begin
            DREQ <= 1'b1;
            DA   <= opa[AW-1:0];
            DWD  <= opb;
            DWE  <= (op == OP_ST);
          end
        end
        MEM: if (DRDY) begin
          DREQ <= 1'b0;
          if (!DWE) wb_val <= DRD;
        end
        WB: begin
          if (rf_we)  rf[rc] <= wb_val;
          if (is_alu) flag   <= alu_zero;
          pc <= npc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc (DW=32): small programs in a behavioural I/D memory
// with optional random 0..3-cycle ready stalls; results checked against hand values.
module tb_cpu_mc;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam logic [3:0] F_ADD = 4'h0, F_SUB = 4'h1, F_SRL = 4'h2, F_SLL = 4'h3, F_AND = 4'h5;
  localparam logic [15:0] HLT = 16'hF000;

  logic          CK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] IA, DA;
  logic          IREQ, DREQ, DWE, RETIRE, HALTED;
  logic          IRDY = 1'b1, DRDY = 1'b1;
  logic [15:0]   ID;
  logic [DW-1:0] DWD, DRD;

  logic [15:0]   imem [64];
  logic [DW-1:0] dmem [16];

  int n_vec = 0, n_err = 0;
  int cyc, ret;

  cpu_mc #(.DW(DW), .AW(AW), .NREG(16)) dut (
    .CK(CK), .RST(RST), .IA(IA), .IREQ(IREQ), .IRDY(IRDY), .ID(ID),
    .DA(DA), .DREQ(DREQ), .DWE(DWE), .DWD(DWD), .DRD(DRD), .DRDY(DRDY),
    .RETIRE(RETIRE), .HALTED(HALTED)
  );

  always #5 CK = ~CK;

  assign ID  = imem[IA[5:0]];
  assign DRD = dmem[DA[3:0]];

  always @(posedge CK)
    if (!RST && DREQ && DRDY && DWE) dmem[DA[3:0]] = DWD;

  // Ready generator: each request waits a random 0..3 cycles when stalling.
  logic stall_en = 1'b0, dhold = 1'b0;
  int   icnt = 0, itgt = 0, dcnt = 0, dtgt = 0;
  always @(posedge CK) begin
    if (IREQ && IRDY) begin icnt = 0; itgt = int'($urandom_range(0, 3)); end
    else if (IREQ) icnt++;
    if (DREQ && DRDY) begin dcnt = 0; dtgt = int'($urandom_range(0, 3)); end
    else if (DREQ) dcnt++;
  end
  always @(negedge CK) begin
    IRDY = !stall_en || (icnt >= itgt);
    DRDY = !dhold && (!stall_en || (dcnt >= dtgt));
  end

  // Fetch address trace and request-stability monitor.
  logic [15:0] ftrace [$];
  logic        ipend = 1'b0, dpend = 1'b0;
  logic [15:0] ia_h;
  logic [48:0] d_h;
  int          viol = 0;
  always @(posedge CK) begin
    if (IREQ && IRDY) ftrace.push_back(IA);
    if (IREQ) begin
      if (ipend && IA !== ia_h) viol++;
      ia_h = IA; ipend = !IRDY;
    end else ipend = 1'b0;
    if (DREQ) begin
      if (dpend && {DA, DWE, DWD} !== d_h) viol++;
      d_h = {DA, DWE, DWD}; dpend = !DRDY;
    end else dpend = 1'b0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu(input logic [3:0] f, input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
    return {f, c, a, b};
  endfunction
  function automatic logic [15:0] li(input logic [3:0] c, input logic [7:0] v);  return {4'hC, c, v}; endfunction
  function automatic logic [15:0] lui(input logic [3:0] c, input logic [7:0] v); return {4'hD, c, v}; endfunction
  function automatic logic [15:0] ld(input logic [3:0] c, input logic [3:0] a);  return {4'hB, c, a, 4'h0}; endfunction
  function automatic logic [15:0] st(input logic [3:0] a, input logic [3:0] b);  return {4'hA, 4'h0, a, b}; endfunction
  function automatic logic [15:0] jmp(input logic [3:0] c, input logic [3:0] b); return {4'h8, c, 4'h0, b}; endfunction
  function automatic logic [15:0] br(input logic [3:0] b);                       return {4'h9, 8'h00, b}; endfunction

  task automatic clr();
    for (int i = 0; i < 64; i++) imem[i] = HLT;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge CK); RST = 1'b1;
    repeat (2) @(negedge CK);
    RST = 1'b0;
    ftrace.delete();
  endtask

  // Runs from reset release until HALTED; cycle count excludes the HALT state.
  task automatic run_prog(input string tag, output int c, output int r);
    c = 0; r = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge CK); c++;
      @(negedge CK);
      if (RETIRE) r++;
      if (HALTED) break;
    end
    chk({tag, "_halted"}, HALTED, 1);
  endtask

  task automatic load_mul();
    clr();
    imem[0]  = li(5, 1);              imem[1]  = ld(1, 0);
    imem[2]  = ld(2, 5);              imem[3]  = li(6, 2);
    imem[4]  = li(7, 7);              imem[5]  = li(8, 10);
    imem[6]  = li(9, 14);             imem[7]  = alu(F_AND, 10, 2, 5);
    imem[8]  = br(8);                 imem[9]  = alu(F_ADD, 3, 3, 1);
    imem[10] = alu(F_SLL, 1, 1, 5);   imem[11] = alu(F_SRL, 2, 2, 5);
    imem[12] = br(9);                 imem[13] = jmp(15, 7);
    imem[14] = st(6, 3);              imem[15] = HLT;
    dmem[0] = 2; dmem[1] = 255;
  endtask

  int exp3 [12] = '{0, 1, 2, 5, 6, 7, 8, 9, 11, 12, 13, 14};

  initial begin
    clr();
    repeat (3) @(negedge CK);
    chk("rst_ireq", IREQ, 0);     chk("rst_dreq", DREQ, 0);
    chk("rst_ia", IA, 0);         chk("rst_da", DA, 0);
    chk("rst_dwe", DWE, 0);       chk("rst_dwd", DWD, 0);
    chk("rst_retire", RETIRE, 0); chk("rst_halted", HALTED, 0);

    // 1: zero-wait multiply 2*255; 7 prefix + 55 loop + store + halt
    load_mul();
    do_reset();
    run_prog("t1", cyc, ret);
    chk("t1_dmem2", dmem[2], 510);
    chk("t1_retires", ret, 64);
    chk("t1_cycles", cyc, 259);

    // 2: same program with random stalls
    load_mul();
    stall_en = 1'b1; viol = 0;
    do_reset();
    run_prog("t2", cyc, ret);
    chk("t2_dmem2", dmem[2], 510);
    chk("t2_retires", ret, 64);
    chk("t2_stable", viol, 0);
    chk("t2_stalled", cyc > 259, 1);
    stall_en = 1'b0;

    // 3: branch taken, branch not taken, jump with link
    clr();
    imem[0]  = li(2, 5);             imem[1]  = alu(F_SUB, 1, 1, 1);
    imem[2]  = br(2);                imem[3]  = li(3, 8'hAA);
    imem[4]  = HLT;                  imem[5]  = li(4, 3);
    imem[6]  = alu(F_ADD, 5, 4, 4);  imem[7]  = br(2);
    imem[8]  = li(6, 11);            imem[9]  = jmp(15, 6);
    imem[10] = li(3, 8'hBB);         imem[11] = st(0, 15);
    imem[12] = li(7, 1);             imem[13] = st(7, 3);
    dmem[0] = 32'h55; dmem[1] = 32'h55;
    do_reset();
    run_prog("t3", cyc, ret);
    chk("t3_retires", ret, 12);
    chk("t3_link", dmem[0], 10);
    chk("t3_skipped", dmem[1], 0);
    chk("t3_trace_len", ftrace.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("t3_pc%0d", i), (i < ftrace.size()) ? ftrace[i] : 16'hFFFF, exp3[i]);

    // 4: 32-bit width corners
    clr();
    imem[0]  = li(1, 8'hFF);          imem[1]  = lui(1, 8'h12);
    imem[2]  = li(2, 40);             imem[3]  = alu(F_SLL, 3, 1, 2);
    imem[4]  = li(4, 1);              imem[5]  = alu(F_SUB, 5, 0, 4);
    imem[6]  = alu(F_ADD, 6, 5, 4);   imem[7]  = li(7, 10);
    imem[8]  = br(7);                 imem[9]  = li(8, 8'hEE);
    imem[10] = st(0, 1);              imem[11] = st(4, 3);
    imem[12] = li(9, 2);              imem[13] = st(9, 5);
    imem[14] = li(9, 3);              imem[15] = st(9, 6);
    imem[16] = li(9, 4);              imem[17] = st(9, 8);
    imem[18] = li(10, 31);            imem[19] = alu(F_SRL, 11, 5, 10);
    imem[20] = li(9, 5);              imem[21] = st(9, 11);
    imem[22] = lui(5, 8'hAB);         imem[23] = li(9, 6);
    imem[24] = st(9, 5);
    for (int i = 0; i < 7; i++) dmem[i] = 32'h5A5A5A5A;
    do_reset();
    run_prog("t4", cyc, ret);
    chk("t4_lui", dmem[0], 32'h000012FF);
    chk("t4_shl40", dmem[1], 0);
    chk("t4_sub", dmem[2], 32'hFFFFFFFF);
    chk("t4_wrap", dmem[3], 0);
    chk("t4_flag_br", dmem[4], 0);
    chk("t4_srl31", dmem[5], 1);
    chk("t4_lui_keep", dmem[6], 32'hFFFFABFF);

    // 5: reset during a stalled load
    clr();
    imem[0] = li(1, 7); imem[1] = ld(2, 1);
    dmem[7] = 32'h77;
    dhold = 1'b1;
    do_reset();
    begin
      int w = 0;
      while (!DREQ && w < 50) begin @(negedge CK); w++; end
    end
    chk("t5_dreq_seen", DREQ, 1);
    repeat (3) @(negedge CK);
    chk("t5_dreq_held", DREQ, 1);
    chk("t5_da_held", DA, 7);
    RST = 1'b1;
    @(negedge CK);
    chk("t5_dreq_drop", DREQ, 0);
    chk("t5_pc0", IA, 0);
    clr();
    imem[0] = st(0, 1); imem[1] = li(3, 4); imem[2] = st(3, 2);
    dmem[0] = 32'h33; dmem[4] = 32'h44;
    dhold = 1'b0;
    RST = 1'b0;
    ftrace.delete();
    #1;
    chk("t5_refetch_req", IREQ, 1);
    chk("t5_refetch_ia", IA, 0);
    run_prog("t5", cyc, ret);
    chk("t5_r1_clear", dmem[0], 0);
    chk("t5_r2_clear", dmem[4], 0);
    chk("t5_cycles", cyc, 18);

    // 6: HALT at address 3, hold, then restart
    clr();
    imem[0] = li(1, 1); imem[1] = li(2, 2); imem[2] = alu(F_ADD, 3, 1, 2);
    do_reset();
    run_prog("t6", cyc, ret);
    chk("t6_retires", ret, 4);
    chk("t6_cycles", cyc, 16);
    begin
      int bad = 0;
      repeat (20) begin
        @(negedge CK);
        if (!HALTED || IREQ || DREQ || RETIRE) bad++;
      end
      chk("t6_hold", bad, 0);
    end
    do_reset();
    chk("t6_unhalt", HALTED, 0);
    run_prog("t6b", cyc, ret);
    chk("t6b_retires", ret, 4);
    chk("t6b_first_fetch", (ftrace.size() > 0) ? ftrace[0] : 16'hFFFF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
